// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types: standard mode constants, sync polarities,
// the timing-flag bundle carried through the delay line, and the colour-bar helper.
package vga_timing_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam vga_timing_t VGA_800x600_72 = '{800, 56, 120, 64, 600, 37, 6, 23};

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // Syncs are carried active-high here; polarity is applied at the output register.
    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
        logic frame_start;
        logic line_start;
    } timing_flags_t;

    localparam timing_flags_t FLAGS_IDLE = '{hblank: 1'b1, vblank: 1'b1, default: 1'b0};

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_sel_t;

    function automatic rgb_sel_t bar_colour(input logic [2:0] idx);
        rgb_sel_t sel;
        sel.r = idx[2];
        sel.g = idx[1];
        sel.b = idx[0];
        return sel;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register of configurable width and depth with a
// synchronous reset to a caller-chosen idle value.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator; sync/blank/colour are delayed to meet client fetch latency.
// Optional VGA_TEST_PATTERN_EN adds a TEST_MODE input that replaces client colour with 8 bars.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter bit HS_POL        = 1'b0,
    parameter bit VS_POL        = 1'b0,
    parameter int R_W           = 3,
    parameter int G_W           = 3,
    parameter int B_W           = 2,
    parameter int FETCH_LATENCY = 1,
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW           = $clog2(H_TOTAL),
    localparam int YW           = $clog2(V_TOTAL),
    localparam int CW           = R_W + G_W + B_W
) (
    input  logic          CLK_PIXEL,
    input  logic          RESET,
    input  logic          ENABLE,
`ifdef VGA_TEST_PATTERN_EN
    input  logic          TEST_MODE,
`endif
    input  logic [CW-1:0] COLOR_DATA_IN,
    output logic [XW-1:0] CURX,
    output logic [YW-1:0] CURY,
    output logic          DATA_REQ,
    output logic          HS,
    output logic          VS,
    output logic          HBLANK,
    output logic          VBLANK,
    output logic          BLANK,
    output logic [R_W-1:0] RED,
    output logic [G_W-1:0] GREEN,
    output logic [B_W-1:0] BLUE,
    output logic          FRAME_START,
    output logic          LINE_START
);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [XW-1:0] h_q, h_d;
    logic [YW-1:0] v_q, v_d;
    logic [31:0]   h_ext, v_ext;
    logic          h_act, v_act, req;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (ENABLE) begin
            if (h_q == XW'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == YW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_PIXEL) begin
        if (RESET) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_ext = 32'(h_q);
    assign v_ext = 32'(v_q);
    assign h_act = h_ext < H_ACTIVE;
    assign v_act = v_ext < V_ACTIVE;

    // Request is masked while reset is held so the idle state shows no request.
    assign req      = h_act & v_act & ~RESET;
    assign DATA_REQ = req;
    assign CURX     = req ? h_q : '0;
    assign CURY     = req ? v_q : '0;

    timing_flags_t flags_raw, flags_tail;

    always_comb begin
        flags_raw             = FLAGS_IDLE;
        flags_raw.hblank      = ~h_act;
        flags_raw.vblank      = ~v_act;
        flags_raw.hsync       = (h_ext >= HS_START) && (h_ext < HS_END);
        flags_raw.vsync       = (v_ext >= VS_START) && (v_ext < VS_END);
        flags_raw.frame_start = (h_q == '0) && (v_q == '0);
        flags_raw.line_start  = (h_q == '0) && v_act;
    end

    vga_delay_line #(
        .WIDTH   ($bits(timing_flags_t)),
        .DEPTH   (FETCH_LATENCY),
        .RST_VAL (FLAGS_IDLE)
    ) u_flag_delay (
        .clk_i  (CLK_PIXEL),
        .srst_i (RESET),
        .en_i   (ENABLE),
        .d_i    (flags_raw),
        .q_o    (flags_tail)
    );

    logic [CW-1:0] colour_src;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [XW-1:0] x_tail;
    logic [6:0]    bar_ge;
    logic [2:0]    bar_idx;
    rgb_sel_t      bar_sel;

    // The x coordinate travels alongside the flags so bars line up with BLANK.
    vga_delay_line #(
        .WIDTH   (XW),
        .DEPTH   (FETCH_LATENCY),
        .RST_VAL ('0)
    ) u_x_delay (
        .clk_i  (CLK_PIXEL),
        .srst_i (RESET),
        .en_i   (ENABLE),
        .d_i    (h_q),
        .q_o    (x_tail)
    );

    for (genvar gi = 1; gi < 8; gi++) begin : g_bar
        assign bar_ge[gi-1] = 32'(x_tail) >= gi * BAR_W;
    end

    assign bar_idx    = 3'($countones(bar_ge));
    assign bar_sel    = bar_colour(bar_idx);
    assign colour_src = TEST_MODE ? {{R_W{bar_sel.r}}, {G_W{bar_sel.g}}, {B_W{bar_sel.b}}}
                                  : COLOR_DATA_IN;
`else
    assign colour_src = COLOR_DATA_IN;
`endif

    logic [CW-1:0] colour_q, colour_d;
    logic          hblank_q, vblank_q, hs_q, vs_q, fs_q, ls_q;

    always_comb begin
        colour_d = colour_src;
        if (flags_tail.hblank | flags_tail.vblank) begin
            colour_d = '0;
        end
    end

    always_ff @(posedge CLK_PIXEL) begin
        if (RESET) begin
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            hs_q     <= ~HS_POL;
            vs_q     <= ~VS_POL;
            fs_q     <= 1'b0;
            ls_q     <= 1'b0;
            colour_q <= '0;
        end else if (ENABLE) begin
            hblank_q <= flags_tail.hblank;
            vblank_q <= flags_tail.vblank;
            hs_q     <= flags_tail.hsync ? HS_POL : ~HS_POL;
            vs_q     <= flags_tail.vsync ? VS_POL : ~VS_POL;
            fs_q     <= flags_tail.frame_start;
            ls_q     <= flags_tail.line_start;
            colour_q <= colour_d;
        end
    end

    assign HBLANK      = hblank_q;
    assign VBLANK      = vblank_q;
    assign BLANK       = hblank_q | vblank_q;
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign FRAME_START = fs_q;
    assign LINE_START  = ls_q;
    assign RED         = colour_q[CW-1 -: R_W];
    assign GREEN       = colour_q[B_W +: G_W];
    assign BLUE        = colour_q[B_W-1:0];

endmodule
